aes_mode_ctrl: RTL and testbench

Block-chaining and flow-control front end for the masked AES decryption core. Accepts a key of configurable length, a per-message mode and IV, and a stream of ciphertext blocks buffered in a FIFO. Issues blocks to the core one at a time over a valid/ready handshake and applies ECB or CBC post-processing. Returns plaintext with output backpressure and a message-last flag.

---
 rtl/aes_mode_pkg.sv | 30 +++
 rtl/aes_blk_fifo.sv | 53 +++++
 rtl/aes_mode_ctrl.sv | 162 ++++++++++++++++
 tb/tb_aes_mode_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mode_pkg.sv
// Shared types and key-length helpers for the AES decryption mode controller.
package aes_mode_pkg;

    typedef enum logic [1:0] {
        MODE_ECB = 2'b00,
        MODE_CBC = 2'b01
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        KEYLD,
        RUN,
        ISSUE,
        WAIT,
        OUT
    } state_e;

    localparam logic [1:0] KLEN_128 = 2'd0;
    localparam logic [1:0] KLEN_192 = 2'd1;
    localparam logic [1:0] KLEN_256 = 2'd2;

    function automatic logic [1:0] klen_of(input int key_bits);
        case (key_bits)
            128:     return KLEN_128;
            192:     return KLEN_192;
            default: return KLEN_256;
        endcase
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Show-ahead synchronous FIFO holding {ciphertext, last} entries; flags are registered.
module aes_blk_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and flags alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + ONE;
            if (push_ok && !pop_ok) begin
                empty <= 1'b0;
                full  <= (wr_ptr + ONE) == rd_ptr;
            end else if (pop_ok && !push_ok) begin
                full  <= 1'b0;
                empty <= (rd_ptr + ONE) == wr_ptr;
            end
        end
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC chaining and flow-control front end for the AES decryption core.
module aes_mode_ctrl
    import aes_mode_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic [KEY_BITS-1:0] k_i,
    input  logic                kvalid_i,
    output logic                key_ready_o,
    input  logic [1:0]          mode_i,
    input  logic [127:0]        iv_i,
    input  logic                start_i,
    input  logic [127:0]        c_i,
    input  logic                clast_i,
    input  logic                cvalid_i,
    output logic                cready_o,
    output logic [127:0]        plain_o,
    output logic                plast_o,
    output logic                pvalid_o,
    input  logic                pready_i,
    output logic                busy_o,
    output logic                err_o,
    output logic [255:0]        core_k_o,
    output logic [1:0]          core_klen_o,
    output logic                core_kvalid_o,
    input  logic                core_kready_i,
    output logic [127:0]        core_blk_o,
    output logic                core_bvalid_o,
    input  logic                core_bready_i,
    input  logic [127:0]        core_res_i,
    input  logic                core_rvalid_i
);

    state_e        state;
    state_e        state_nx;
    mode_e         mode_q;
    logic          key_loaded;
    logic          last_in;
    logic [127:0]  chain;
    logic [127:0]  cur_c;
    logic          cur_last;

    logic          act;
    logic          busy;
    logic          key_fire;
    logic          kload_done;
    logic          blk_fire;
    logic          res_fire;
    logic          out_fire;
    logic          push;
    logic          pop;
    logic          start_ok;
    logic          err_nx;

    logic          fifo_full;
    logic          fifo_empty;
    logic [128:0]  fifo_rd;

    // Handshake outputs read 0 while stalled or while reset is held.
    assign act  = enable_i && !reset;
    assign busy = state inside {RUN, ISSUE, WAIT, OUT};

    assign key_ready_o   = act && (state == IDLE);
    assign core_kvalid_o = act && (state == KEYLD);
    assign core_bvalid_o = act && (state == ISSUE);
    assign pvalid_o      = act && (state == OUT);
    assign cready_o      = act && busy && !fifo_full && !last_in;
    assign busy_o        = busy;
    assign core_blk_o    = cur_c;

    assign key_fire   = key_ready_o && kvalid_i;
    assign kload_done = core_kvalid_o && core_kready_i;
    assign blk_fire   = core_bvalid_o && core_bready_i;
    assign out_fire   = pvalid_o && pready_i;
    assign push       = cready_o && cvalid_i;
    assign pop        = act && (state == RUN) && !fifo_empty;
    assign res_fire   = act && (state == WAIT) && core_rvalid_i;

    // A simultaneous key transfer takes priority over start.
    assign start_ok = key_ready_o && start_i && !kvalid_i && key_loaded && !mode_i[1];
    assign err_nx   = act && ((start_i && !start_ok) || (core_rvalid_i && state != WAIT));

    aes_blk_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (129)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({c_i, clast_i}),
        .pop   (pop),
        .rdata (fifo_rd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: state_nx gets its default first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (key_fire) state_nx = KEYLD;
                     else if (start_ok) state_nx = RUN;
            KEYLD:   if (kload_done) state_nx = IDLE;
            RUN:     if (pop) state_nx = ISSUE;
            ISSUE:   if (blk_fire) state_nx = WAIT;
            WAIT:    if (res_fire) state_nx = OUT;
            OUT:     if (out_fire) state_nx = plast_o ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_o       <= 1'b0;
            core_k_o    <= '0;
            core_klen_o <= '0;
            key_loaded  <= 1'b0;
            mode_q      <= MODE_ECB;
            chain       <= '0;
            last_in     <= 1'b0;
            cur_c       <= '0;
            cur_last    <= 1'b0;
            plain_o     <= '0;
            plast_o     <= 1'b0;
        end else begin
            err_o <= err_nx;
            if (key_fire) begin
                core_k_o    <= 256'(k_i) << (256 - KEY_BITS);
                core_klen_o <= klen_of(KEY_BITS);
                key_loaded  <= 1'b0;
            end
            if (kload_done) key_loaded <= 1'b1;
            if (start_ok) begin
                mode_q  <= mode_e'(mode_i);
                chain   <= (mode_i == MODE_CBC) ? iv_i : '0;
                last_in <= 1'b0;
            end
            // Once the final block is in, the message accepts nothing further.
            if (push && clast_i) last_in <= 1'b1;
            if (pop) begin
                cur_c    <= fifo_rd[128:1];
                cur_last <= fifo_rd[0];
            end
            if (res_fire) begin
                plain_o <= core_res_i ^ chain;
                plast_o <= cur_last;
                chain   <= (mode_q == MODE_CBC) ? cur_c : '0;
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Scoreboard bench for aes_mode_ctrl with an echoing core stub (result = block, 3 cycles later).
module tb_aes_mode_ctrl;
    import aes_mode_pkg::*;

    logic          clk;
    logic          reset;
    logic          enable_i;
    logic [127:0]  k_i;
    logic          kvalid_i;
    logic          key_ready_o;
    logic [1:0]    mode_i;
    logic [127:0]  iv_i;
    logic          start_i;
    logic [127:0]  c_i;
    logic          clast_i;
    logic          cvalid_i;
    logic          cready_o;
    logic [127:0]  plain_o;
    logic          plast_o;
    logic          pvalid_o;
    logic          pready_i;
    logic          busy_o;
    logic          err_o;
    logic [255:0]  core_k_o;
    logic [1:0]    core_klen_o;
    logic          core_kvalid_o;
    logic          core_kready_i;
    logic [127:0]  core_blk_o;
    logic          core_bvalid_o;
    logic          core_bready_i;
    logic [127:0]  core_res_i;
    logic          core_rvalid_i;

    int            checks;
    int            failures;
    logic [128:0]  exp_q[$];
    logic          stub_check;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

    aes_mode_ctrl #(.DEPTH(4), .KEY_BITS(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .k_i           (k_i),
        .kvalid_i      (kvalid_i),
        .key_ready_o   (key_ready_o),
        .mode_i        (mode_i),
        .iv_i          (iv_i),
        .start_i       (start_i),
        .c_i           (c_i),
        .clast_i       (clast_i),
        .cvalid_i      (cvalid_i),
        .cready_o      (cready_o),
        .plain_o       (plain_o),
        .plast_o       (plast_o),
        .pvalid_o      (pvalid_o),
        .pready_i      (pready_i),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .core_k_o      (core_k_o),
        .core_klen_o   (core_klen_o),
        .core_kvalid_o (core_kvalid_o),
        .core_kready_i (core_kready_i),
        .core_blk_o    (core_blk_o),
        .core_bvalid_o (core_bvalid_o),
        .core_bready_i (core_bready_i),
        .core_res_i    (core_res_i),
        .core_rvalid_i (core_rvalid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {key_ready_o, cready_o, pvalid_o, core_kvalid_o, core_bvalid_o,
                               busy_o, err_o, plast_o, core_klen_o}, '0);
        check({name, "_dat"}, {plain_o, core_blk_o}, '0);
        check({name, "_key"}, core_k_o, '0);
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic [127:0] iv);
        @(posedge clk); #1;
        start_i = 1'b1;
        mode_i  = mode;
        iv_i    = iv;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] key);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        k_i      = key;
        kvalid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_ready_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("key_ready_wait", key_ready_o, 1);
        @(posedge clk); #1;
        kvalid_i = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic push_blk(input logic [127:0] c, input logic last, input logic track,
                            input logic [127:0] exp);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        c_i      = c;
        clast_i  = last;
        cvalid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cready_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("cready_wait", cready_o, 1);
        else if (track) exp_q.push_back({exp, last});
        @(posedge clk); #1;
        cvalid_i = 1'b0;
        clast_i  = 1'b0;
    endtask

    task automatic wait_bvalid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_bvalid_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(name, core_bvalid_o, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_o && exp_q.size() == 0) break;
        end
        check(name, busy_o, 0);
    endtask

    // Scoreboard monitor: every accepted output is compared against the queue head.
    initial begin : monitor
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (pvalid_o && pready_i) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", pvalid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_plain", plain_o, e[128:1]);
                    check("out_last", plast_o, e[0]);
                end
            end
        end
    end

    // Core stub: echoes the block three cycles after its handshake.
    initial begin : core_stub
        logic [127:0] blk;
        core_rvalid_i = 1'b0;
        core_res_i    = '0;
        forever begin
            @(negedge clk);
            if (core_bvalid_o && core_bready_i) begin
                blk = core_blk_o;
                repeat (3) @(posedge clk);
                #1;
                core_res_i    = blk;
                core_rvalid_i = 1'b1;
                @(negedge clk);
                if (stub_check) check("pv_before_res", pvalid_o, 0);
                @(posedge clk); #1;
                core_rvalid_i = 1'b0;
                @(negedge clk);
                if (stub_check) check("pv_after_res", pvalid_o, 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] chain;
        logic [127:0] c;
        checks        = 0;
        failures      = 0;
        stub_check    = 1'b1;
        reset         = 1'b1;
        enable_i      = 1'b1;
        k_i           = '0;
        kvalid_i      = 1'b0;
        mode_i        = 2'b00;
        iv_i          = '0;
        start_i       = 1'b0;
        c_i           = '0;
        clast_i       = 1'b0;
        cvalid_i      = 1'b0;
        pready_i      = 1'b1;
        core_kready_i = 1'b1;
        core_bready_i = 1'b1;

        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // start before any key is loaded
        pulse_start(2'b00, '0);
        @(negedge clk);
        check("nokey_err", err_o, 1);
        check("nokey_busy", busy_o, 0);
        @(negedge clk);
        check("nokey_err_width", err_o, 0);

        load_key(KEY);
        check("klen_128", core_klen_o, KLEN_128);
        check("key_left_aligned", core_k_o, {KEY, 128'h0});

        // reserved mode
        pulse_start(2'b10, '0);
        @(negedge clk);
        check("mode10_err", err_o, 1);
        check("mode10_busy", busy_o, 0);

        // ECB, two blocks; also the push-to-issue latency
        pulse_start(2'b00, '0);
        @(negedge clk);
        check("ecb_busy", busy_o, 1);
        check("ecb_no_err", err_o, 0);
        push_blk({16{8'h11}}, 1'b0, 1'b1, {16{8'h11}});
        @(negedge clk);
        check("lat_t1_bvalid", core_bvalid_o, 0);
        @(negedge clk);
        check("lat_t2_bvalid", core_bvalid_o, 1);
        check("lat_t2_blk", core_blk_o, {16{8'h11}});
        push_blk({16{8'h22}}, 1'b1, 1'b1, {16{8'h22}});
        wait_idle("ecb_idle");

        // CBC chaining; a start during RUN is rejected without disturbing the message
        pulse_start(2'b01, {16{8'h0f}});
        pulse_start(2'b00, '0);
        @(negedge clk);
        check("busy_start_err", err_o, 1);
        check("busy_start_busy", busy_o, 1);
        push_blk({16{8'hf0}}, 1'b0, 1'b1, {16{8'hff}});
        push_blk({16{8'hff}}, 1'b1, 1'b1, {16{8'h0f}});
        @(negedge clk);
        check("clast_cready_drop", cready_o, 0);
        wait_idle("cbc_idle");

        // backpressure: one block held at the output, four queued, then full
        pready_i = 1'b0;
        pulse_start(2'b00, '0);
        for (int i = 1; i <= 5; i++) begin
            c = {16{8'(i * 16 + 3)}};
            push_blk(c, 1'b0, 1'b1, c);
        end
        repeat (8) @(negedge clk);
        check("full_cready", cready_o, 0);
        check("bp_pvalid", pvalid_o, 1);
        check("bp_hold", plain_o, {16{8'h13}});
        @(posedge clk); #1;
        pready_i = 1'b1;
        push_blk({16{8'h63}}, 1'b1, 1'b1, {16{8'h63}});
        wait_idle("bp_idle");

        // stall during ISSUE
        core_bready_i = 1'b0;
        pulse_start(2'b00, '0);
        push_blk({16{8'h5e}}, 1'b1, 1'b1, {16{8'h5e}});
        wait_bvalid("stall_bv_wait");
        @(posedge clk); #1;
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_bvalid", core_bvalid_o, 0);
            check("stall_handshakes", {key_ready_o, cready_o, pvalid_o, core_kvalid_o}, 0);
        end
        @(posedge clk); #1;
        enable_i = 1'b1;
        @(negedge clk);
        check("resume_bvalid", core_bvalid_o, 1);
        check("resume_blk", core_blk_o, {16{8'h5e}});
        @(posedge clk); #1;
        core_bready_i = 1'b1;
        wait_idle("stall_idle");

        // reset while waiting for the core result
        stub_check = 1'b0;
        pulse_start(2'b00, '0);
        push_blk({16{8'h77}}, 1'b1, 1'b0, '0);
        wait_bvalid("rst_bv_wait");
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        stub_check = 1'b1;
        pulse_start(2'b00, '0);
        @(negedge clk);
        check("rst_key_cleared_err", err_o, 1);
        check("rst_key_cleared_busy", busy_o, 0);
        load_key(KEY);

        // three back-to-back CBC messages of five blocks each
        for (int m = 0; m < 3; m++) begin
            chain = {4{32'h5a5a_0000 + 32'(m)}};
            pulse_start(2'b01, chain);
            for (int b = 0; b < 5; b++) begin
                c = {8{16'(m * 256 + b * 17 + 3)}};
                push_blk(c, b == 4, 1'b1, c ^ chain);
                chain = c;
            end
            wait_idle("wrap_idle");
        end

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
